lms_filter: RTL and testbench

LMS_FILTER -- requirements
Module: lms_filter

---
 rtl/lms_filter.sv | 93 +++++++++
 tb/tb_lms_filter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/lms_filter.sv
// lms_filter: N-tap adaptive FIR with an LMS weight update every clock.
// Define LMS_FILTER_SAT_EN to saturate y, e and the weights instead of wrapping.
`timescale 1ns/1ps
module lms_filter #(
   parameter int DATA_WIDTH   = 12,
   parameter int FILTER_ORDER = 5,
   parameter int MU_SHIFT     = 4
) (
   input  logic                         clk_in,
   input  logic                         resetn_in,
   input  logic signed [DATA_WIDTH-1:0] x_in,
   input  logic signed [DATA_WIDTH-1:0] ref_in,
   output logic signed [DATA_WIDTH-1:0] y_out,
   output logic signed [DATA_WIDTH-1:0] err_out
);
   localparam int LOG_N  = (FILTER_ORDER > 1) ? $clog2(FILTER_ORDER) : 0;
   localparam int PROD_W = 2 * DATA_WIDTH;
   localparam int ACC_W  = PROD_W + LOG_N;
   localparam int WIDE_W = ACC_W + 1;

   typedef logic signed [DATA_WIDTH-1:0] word_t;
   typedef logic signed [WIDE_W-1:0]     wide_t;

   function automatic word_t reduce(input wide_t v);
`ifdef LMS_FILTER_SAT_EN
      wide_t maxv;
      wide_t minv;
      maxv = wide_t'({1'b0, {(DATA_WIDTH-1){1'b1}}});
      minv = ~maxv;
      if (v > maxv)
         reduce = maxv[DATA_WIDTH-1:0];
      else if (v < minv)
         reduce = minv[DATA_WIDTH-1:0];
      else
         reduce = v[DATA_WIDTH-1:0];
`else
      reduce = v[DATA_WIDTH-1:0];
`endif
   endfunction

   word_t                    x_q [FILTER_ORDER];
   word_t                    x_d [FILTER_ORDER];
   word_t                    w_q [FILTER_ORDER];
   word_t                    w_d [FILTER_ORDER];
   word_t                    y_q, y_d;
   word_t                    err_q, err_d;
   logic signed [ACC_W-1:0]  acc;
   logic signed [PROD_W-1:0] prod;
   logic signed [PROD_W-1:0] delta;

   always_comb begin
      acc   = '0;
      prod  = '0;
      delta = '0;
      for (int i = 0; i < FILTER_ORDER; i++) begin
         prod = w_q[i] * x_q[i];
         acc  = acc + ACC_W'(prod);
      end
      y_d   = reduce(wide_t'(acc >>> (DATA_WIDTH - 1)));
      err_d = reduce(wide_t'(ref_in) - wide_t'(y_d));

      // Update uses the pre-edge taps and this cycle's error.
      for (int i = 0; i < FILTER_ORDER; i++) begin
         prod   = err_d * x_q[i];
         delta  = prod >>> (DATA_WIDTH - 1 + MU_SHIFT);
         w_d[i] = reduce(wide_t'(w_q[i]) + wide_t'(delta));
      end

      x_d[0] = x_in;
      for (int i = 1; i < FILTER_ORDER; i++)
         x_d[i] = x_q[i-1];
   end

   always_ff @(posedge clk_in or negedge resetn_in) begin
      if (!resetn_in) begin
         for (int i = 0; i < FILTER_ORDER; i++) begin
            x_q[i] <= '0;
            w_q[i] <= '0;
         end
         y_q   <= '0;
         err_q <= '0;
      end else begin
         x_q   <= x_d;
         w_q   <= w_d;
         y_q   <= y_d;
         err_q <= err_d;
      end
   end

   assign y_out   = y_q;
   assign err_out = err_q;

endmodule

// File: tb/tb_lms_filter.sv
// Randomized bench for lms_filter against an integer-arithmetic reference model.
// Build with +define+LMS_FILTER_SAT_EN to check the saturating variant.
`timescale 1ns/1ps
module tb_lms_filter;
   localparam int DW   = 12;
   localparam int N    = 5;
   localparam int MU   = 4;
   localparam int SPAN = 1 << DW;
   localparam int HALF = 1 << (DW - 1);
   localparam int CONV = 3000;

   logic                 clk = 1'b0;
   logic                 resetn = 1'b0;
   logic signed [DW-1:0] x_in = '0;
   logic signed [DW-1:0] ref_in = '0;
   logic signed [DW-1:0] y_out;
   logic signed [DW-1:0] err_out;

   int n_checks = 0;
   int n_errors = 0;

   int xm [N];
   int wm [N];
   int ym, em;
   int xs [CONV];

   lms_filter #(.DATA_WIDTH(DW), .FILTER_ORDER(N), .MU_SHIFT(MU)) dut (
      .clk_in   (clk),
      .resetn_in(resetn),
      .x_in     (x_in),
      .ref_in   (ref_in),
      .y_out    (y_out),
      .err_out  (err_out)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time exhausted, got timeout, required completion");
      $fatal(1);
   end

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int red(input longint v);
`ifdef LMS_FILTER_SAT_EN
      if (v > HALF - 1) return HALF - 1;
      if (v < -HALF) return -HALF;
      return int'(v);
`else
      longint m;
      m = v % SPAN;
      if (m < 0) m += SPAN;
      if (m >= HALF) m -= SPAN;
      return int'(m);
`endif
   endfunction

   function automatic int rnd();
      return int'($urandom_range(0, SPAN - 1)) - HALF;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         xm[i] = 0;
         wm[i] = 0;
      end
      ym = 0;
      em = 0;
   endtask

   // One clock of the LMS recurrence, written directly from the equations.
   task automatic model_step(input int xv, input int rv);
      longint acc;
      int     yv, ev;
      int     wn [N];
      acc = 0;
      for (int i = 0; i < N; i++) acc += longint'(wm[i]) * xm[i];
      yv = red(acc >>> (DW - 1));
      ev = red(longint'(rv) - yv);
      for (int i = 0; i < N; i++)
         wn[i] = red(longint'(wm[i]) + ((longint'(ev) * xm[i]) >>> (DW - 1 + MU)));
      for (int i = N - 1; i > 0; i--) xm[i] = xm[i-1];
      xm[0] = xv;
      wm = wn;
      ym = yv;
      em = ev;
   endtask

   // Called at a falling edge; returns at the next falling edge.
   task automatic cyc(input int xv, input int rv);
      x_in   = DW'(xv);
      ref_in = DW'(rv);
      if (resetn) model_step(xv, rv);
      else model_reset();
      @(posedge clk);
      #1;
      check("y_out", int'(y_out), ym);
      check("err_out", int'(err_out), em);
      @(negedge clk);
   endtask

   task automatic chk_state(input string tag);
      for (int i = 0; i < N; i++) begin
         check($sformatf("%s_w%0d", tag, i), int'(dut.w_q[i]), wm[i]);
         check($sformatf("%s_x%0d", tag, i), int'(dut.x_q[i]), xm[i]);
      end
   endtask

   task automatic chk_zero(input string tag);
      check({tag, "_y"}, int'(y_out), 0);
      check({tag, "_err"}, int'(err_out), 0);
      for (int i = 0; i < N; i++) begin
         check($sformatf("%s_w%0d", tag, i), int'(dut.w_q[i]), 0);
         check($sformatf("%s_x%0d", tag, i), int'(dut.x_q[i]), 0);
      end
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      model_reset();
      #1;
      chk_zero("rst_async");
      @(negedge clk);
      repeat (3) cyc(rnd(), rnd());
      chk_zero("rst_held");
      resetn = 1'b1;
   endtask

   task automatic conv_run(input int ncyc);
      for (int k = 0; k < ncyc; k++)
         cyc(xs[k], (k == 0) ? 0 : (xs[k-1] >>> 1));
   endtask

   int minw;

   initial begin
      model_reset();
      @(negedge clk);
      do_reset();

      // Release with no input: error tracks the reference, weights stay zero.
      for (int k = 0; k < 4; k++) begin
         cyc(0, 100);
         check("rel_err100", int'(err_out), 100);
         check("rel_y0", int'(y_out), 0);
      end
      chk_zero_w: for (int i = 0; i < N; i++)
         check($sformatf("rel_w%0d", i), int'(dut.w_q[i]), 0);

      // First adaptation step and the output it produces.
      do_reset();
      cyc(1024, 0);
      cyc(1024, 512);
      check("first_err", int'(err_out), 512);
      check("first_w0", int'(dut.w_q[0]), 16);
      for (int i = 1; i < N; i++)
         check($sformatf("first_w%0d", i), int'(dut.w_q[i]), 0);
      cyc(0, -2048);
      check("after_y", int'(y_out), 8);
`ifdef LMS_FILTER_SAT_EN
      check("after_err_sat", int'(err_out), -2048);
`else
      check("after_err_wrap", int'(err_out), 2040);
`endif
      chk_state("after");

      // Full-range random x and ref.
      do_reset();
      repeat (300) cyc(rnd(), rnd());
      chk_state("rand");

      // Convergence toward w0 = 0.5, interrupted by a mid-cycle reset.
      for (int k = 0; k < CONV; k++) xs[k] = rnd();
      do_reset();
      conv_run(CONV / 2);
      #2;
      resetn = 1'b0;
      model_reset();
      #1;
      chk_zero("midrst");
      @(negedge clk);
      resetn = 1'b1;
      conv_run(CONV);
      chk_state("conv");
      check("conv_w0_near_1024", int'(dut.w_q[0] >= 768 && dut.w_q[0] <= 1280), 1);
      for (int i = 1; i < N; i++)
         check($sformatf("conv_w%0d_small", i),
               int'(dut.w_q[i] >= -128 && dut.w_q[i] <= 128), 1);

      // Constant full-scale drive pushing the weights upward.
      do_reset();
      minw = 0;
      for (int k = 0; k < 500; k++) begin
         cyc(2047, 2047);
         for (int i = 0; i < N; i++)
            if (int'(dut.w_q[i]) < minw) minw = int'(dut.w_q[i]);
      end
      chk_state("sat");
`ifdef LMS_FILTER_SAT_EN
      check("sat_no_sign_flip", minw, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
